// File: rtl/alu_exec_stage.sv
// alu_exec_stage: execute-stage ALU with one-bit-per-cycle shifts and a valid/ready output register
module alu_exec_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_sel,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic [4:0]      shamt,
  input  logic [4:0]      rd_in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic [4:0]      rd_out,
  output logic            busy
);
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;
  logic [0:0]      state_q, state_d;
  logic [XLEN-1:0] acc_q, acc_d, result_q, result_d, alu_res;
  logic [4:0]      cnt_q, cnt_d, tag_q, tag_d, rd_q, rd_d;
  logic            dir_q, dir_d, out_valid_q, out_valid_d, zero_q, zero_d;
  logic            slot_free, accept, is_shift, slt;
  assign slot_free = !out_valid_q || out_ready;
  assign in_ready  = (state_q == IDLE) && slot_free;
  assign accept    = in_valid && in_ready;
  assign is_shift  = (alu_sel == 4'b1000) || (alu_sel == 4'b1001);
  assign slt       = $signed(op_a) < $signed(op_b);
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero      = zero_q;
  assign rd_out    = rd_q;
  assign busy      = state_q == SHIFT;
  // Single-cycle result; a shift only lands here with shamt==0, so it passes op_b through
  always_comb begin
    alu_res = alu_sel == 4'b0000 ? op_a & op_b :
              alu_sel == 4'b0001 ? op_a | op_b :
              alu_sel == 4'b0010 ? op_a ^ op_b :
              alu_sel == 4'b0100 ? op_a - op_b :
              alu_sel == 4'b0111 ? {{(XLEN-1){1'b0}}, slt} :
              is_shift           ? op_b :
                                   op_a + op_b;
  end
  // Next-state: accept/issue in IDLE, iterate and retire in SHIFT; a consume always frees the slot
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    dir_d       = dir_q;
    tag_d       = tag_q;
    result_d    = result_q;
    zero_d      = zero_q;
    rd_d        = rd_q;
    out_valid_d = out_valid_q && !out_ready;
    if (state_q == IDLE) begin
      if (accept && is_shift && shamt != 5'd0) begin
        state_d = SHIFT;
        acc_d   = op_b;
        cnt_d   = shamt;
        dir_d   = alu_sel[0];
        tag_d   = rd_in;
      end else if (accept) begin
        result_d    = alu_res;
        zero_d      = alu_res == '0;
        rd_d        = rd_in;
        out_valid_d = 1'b1;
      end
    end else if (cnt_q != 5'd0) begin
      acc_d = dir_q ? acc_q >> 1 : acc_q << 1;
      cnt_d = cnt_q - 5'd1;
    end else if (slot_free) begin
      result_d    = acc_q;
      zero_d      = acc_q == '0;
      rd_d        = tag_q;
      out_valid_d = 1'b1;
      state_d     = IDLE;
    end
  end
  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      dir_q       <= 1'b0;
      tag_q       <= '0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      rd_q        <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      dir_q       <= dir_d;
      tag_q       <= tag_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      rd_q        <= rd_d;
      out_valid_q <= out_valid_d;
    end
  end
endmodule

// File: tb/tb_alu_exec_stage.sv
// tb_alu_exec_stage: directed and randomized checks against a transaction-level model
module tb_alu_exec_stage;
  logic        clk = 0, rst = 1, in_valid = 0, out_ready = 0;
  logic [3:0]  alu_sel = 0;
  logic [31:0] op_a = 0, op_b = 0;
  logic [4:0]  shamt = 0, rd_in = 0;
  logic        in_ready, out_valid, zero, busy;
  logic [31:0] result;
  logic [4:0]  rd_out;
  int n_cmp = 0, n_bad = 0;
  bit chk = 0;
  alu_exec_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .alu_sel(alu_sel),
    .op_a(op_a), .op_b(op_b), .shamt(shamt), .rd_in(rd_in), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .zero(zero), .rd_out(rd_out), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic logic [31:0] ref_op(input logic [3:0] s, input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh);
    case (s)
      4'd0: return a & b;
      4'd1: return a | b;
      4'd2: return a ^ b;
      4'd4: return a - b;
      4'd7: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd8: return b << sh;
      4'd9: return b >> sh;
      default: return a + b;
    endcase
  endfunction
  // Model: result slot plus at most one pending shift that retires at a due cycle
  logic        m_valid = 0, m_busy = 0;
  logic [31:0] m_res = 0, m_pv = 0;
  logic [4:0]  m_rd = 0, m_prd = 0;
  longint      cyc = 0, m_due = 0;
  always @(posedge clk) begin
    bit free;
    cyc++;
    free = !m_valid || out_ready;
    if (rst) begin
      m_valid = 0; m_busy = 0; m_res = 0; m_rd = 0;
    end else if (m_busy) begin
      if (cyc >= m_due && free) begin
        m_valid = 1; m_res = m_pv; m_rd = m_prd; m_busy = 0;
      end else if (out_ready) m_valid = 0;
    end else if (in_valid && free) begin
      if ((alu_sel == 8 || alu_sel == 9) && shamt != 0) begin
        m_busy = 1; m_due = cyc + shamt + 1; m_pv = ref_op(alu_sel, op_a, op_b, shamt); m_prd = rd_in; m_valid = 0;
      end else begin
        m_valid = 1; m_res = ref_op(alu_sel, op_a, op_b, shamt); m_rd = rd_in;
      end
    end else if (out_ready) m_valid = 0;
  end
  // Compare every cycle, away from the active edge
  always @(negedge clk) if (chk) begin
    check("out_valid", out_valid, m_valid);
    check("in_ready", in_ready, !m_busy && (!m_valid || out_ready));
    check("busy", busy, m_busy);
    if (m_valid) begin
      check("result", result, m_res);
      check("zero", zero, m_res == 0);
      check("rd_out", rd_out, m_rd);
    end
  end
  task automatic step();
    @(posedge clk); #1;
  endtask
  task automatic issue(input logic [3:0] s, input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh, input logic [4:0] rd);
    in_valid = 1; alu_sel = s; op_a = a; op_b = b; shamt = sh; rd_in = rd;
  endtask
  initial begin
    int n;
    bit seen;
    in_valid = 1; alu_sel = 3;
    step(); chk = 1; step();
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_result", result, 0);
    check("rst_zero", zero, 0);
    check("rst_busy", busy, 0);
    rst = 0; in_valid = 0;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    step(); issue(3, 32'hFFFF_FFFF, 32'h1, 0, 5); out_ready = 1;
    step(); in_valid = 0;
    @(negedge clk);
    check("add_valid", out_valid, 1);
    check("add_result", result, 32'h0);
    check("add_zero", zero, 1);
    check("add_rd", rd_out, 5);
    step(); issue(7, 32'hFFFF_FFFE, 32'h1, 0, 6);
    step(); issue(4, 32'd5, 32'd7, 0, 7);
    @(negedge clk);
    check("slt_result", result, 32'h1);
    check("slt_rd", rd_out, 6);
    step(); in_valid = 0;
    @(negedge clk);
    check("sub_valid", out_valid, 1);
    check("sub_result", result, 32'hFFFF_FFFE);
    check("sub_zero", zero, 0);
    step(); issue(8, 0, 32'h1, 4, 9);
    step(); in_valid = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("sll_busy_noready", {busy, in_ready}, 2'b10);
    end
    @(negedge clk);
    check("sll_valid", out_valid, 1);
    check("sll_result", result, 32'h10);
    check("sll_rd", rd_out, 9);
    step(); issue(9, 0, 32'h8000_0000, 31, 10);
    step(); in_valid = 0;
    n = 0;
    while (out_valid !== 1'b1 && n < 40) begin step(); n++; end
    check("srl_latency", n, 32);
    check("srl_result", result, 32'h1);
    out_ready = 0; issue(3, 32'd1, 32'd2, 0, 11);
    @(negedge clk);
    check("bp_in_ready", in_ready, 0);
    check("bp_result", result, 32'h1);
    step();
    @(negedge clk);
    check("bp_stable", result, 32'h1);
    check("bp_rd_stable", rd_out, 10);
    step(); out_ready = 1;
    @(negedge clk);
    check("bp_release_ready", in_ready, 1);
    step(); in_valid = 0;
    @(negedge clk);
    check("bp_new_result", result, 32'h3);
    check("bp_new_rd", rd_out, 11);
    step(); issue(9, 0, 32'h8000_0000, 31, 12);
    step(); in_valid = 0;
    step(); step(); rst = 1;
    step(); rst = 0;
    @(negedge clk);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_ready", in_ready, 1);
    seen = 0;
    repeat (40) begin step(); seen |= out_valid; end
    check("mid_rst_no_emit", seen, 0);
    for (int i = 0; i < 3000; i++) begin
      rst = $urandom_range(0, 499) == 0;
      in_valid = $urandom_range(0, 9) < 7;
      alu_sel = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 2) == 0) alu_sel = $urandom_range(0, 1) ? 4'd8 : 4'd9;
      op_a = $urandom_range(0, 5) == 0 ? 32'hFFFF_FFFF : $urandom;
      op_b = $urandom_range(0, 5) == 0 ? 32'h8000_0000 : $urandom;
      shamt = $urandom_range(0, 3) == 0 ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 3));
      rd_in = 5'($urandom);
      out_ready = $urandom_range(0, 3) != 0;
      step();
    end
    rst = 0; in_valid = 0; out_ready = 1;
    repeat (40) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
